cdc_fifo_rd_stream: RTL and testbench

- Read-side output stage of the async CDC FIFO, in the r_clk domain, directly downstream of the read-pointer/empty logic and the dual-port BRAM.
- Consumes r_empty and registered BRAM read data; drives the pointer-advance request r_inc.
- Presents words as a first-word-fall-through valid/ready stream with a 2-entry output buffer, sustaining 1 word/cycle despite the 1-cycle BRAM read latency.

---
 rtl/cdc_fifo_rd_stream.sv | 96 +++++++++
 tb/tb_cdc_fifo_rd_stream.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cdc_fifo_rd_stream.sv
// Read-side FWFT stream stage of the async CDC FIFO (r_clk domain).
// Define CDC_FIFO_RD_STREAM_CNT_EN to add the r_pop_cnt accepted-word counter.
module cdc_fifo_rd_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  r_clk,
  input  logic                  r_rst_n,
  input  logic                  r_empty,
  output logic                  r_inc,
  input  logic [DATA_WIDTH-1:0] r_mem_data,
  output logic                  r_valid,
  input  logic                  r_ready,
  output logic [DATA_WIDTH-1:0] r_data
`ifdef CDC_FIFO_RD_STREAM_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]  r_pop_cnt
`endif
);

  if (CNT_WIDTH < 1) begin : g_cnt_w_chk
    $error("CNT_WIDTH must be at least 1");
  end

  logic [DATA_WIDTH-1:0] buf0;
  logic [DATA_WIDTH-1:0] buf1;
  logic [1:0]            occ;
  logic                  inflight;

  logic                  pop;
  logic [2:0]            used;
  logic [2:0]            room;
  logic [2:0]            credit;
  logic [2:0]            occ_sum;
  logic                  head_free;
  logic                  shift;
  logic                  wr_head;
  logic                  wr_tail;

  // used = words held or already requested from the BRAM
  always_comb begin
    pop       = r_valid & r_ready;
    used      = {1'b0, occ} + {2'b0, inflight};
    room      = 3'd2 + {2'b0, pop};
    credit    = (room > used) ? (room - used) : 3'd0;
    r_inc     = r_rst_n & ~r_empty & (credit != 3'd0);
    occ_sum   = used - {2'b0, pop};
    head_free = (occ == 2'd0) | ((occ == 2'd1) & pop);
    shift     = pop & (occ == 2'd2);
    wr_head   = inflight & head_free;
    wr_tail   = inflight & ~head_free & ~shift;
  end

  assign r_valid = (occ != 2'd0);
  assign r_data  = buf0;

  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      occ      <= occ_sum[1:0];
      inflight <= r_inc;
    end
  end

  // a shifting pop and an arriving word land in buf1 together
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) begin
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      unique case (1'b1)
        shift: begin
          buf0 <= buf1;
          if (inflight) buf1 <= r_mem_data;
        end
        wr_head: buf0 <= r_mem_data;
        wr_tail: buf1 <= r_mem_data;
        default: ;
      endcase
    end
  end

`ifdef CDC_FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge r_clk or negedge r_rst_n) begin
    if (!r_rst_n) r_pop_cnt <= '0;
    else if (pop) r_pop_cnt <= r_pop_cnt + 1'b1;
  end
`endif

  a_occ_max: assert property (
    @(posedge r_clk) disable iff (!r_rst_n) occ_sum <= 3'd2
  );

endmodule

// File: tb/tb_cdc_fifo_rd_stream.sv
// Bench for cdc_fifo_rd_stream: vector table, directed sequences and a
// random run against a fetch-time/queue model of the FIFO read stream.
module tb_cdc_fifo_rd_stream;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          r_clk = 1'b0;
  logic          r_rst_n = 1'b0;
  logic          r_empty = 1'b1;
  logic          r_inc;
  logic [DW-1:0] r_mem_data = '0;
  logic          r_valid;
  logic          r_ready = 1'b0;
  logic [DW-1:0] r_data;
`ifdef CDC_FIFO_RD_STREAM_CNT_EN
  logic [CW-1:0] r_pop_cnt;
`endif

  cdc_fifo_rd_stream #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .r_clk      (r_clk),
    .r_rst_n    (r_rst_n),
    .r_empty    (r_empty),
    .r_inc      (r_inc),
    .r_mem_data (r_mem_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_data     (r_data)
`ifdef CDC_FIFO_RD_STREAM_CNT_EN
    ,
    .r_pop_cnt  (r_pop_cnt)
`endif
  );

  always #5 r_clk = ~r_clk;

  typedef struct {
    logic          rst_n;
    logic          empty;
    logic          ready;
    logic [DW-1:0] mem;
    logic          exp_valid;
    logic          exp_inc;
    logic          chk_data;
    logic [DW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [DW-1:0] w;
    int            t;
  } item_t;

  int            n_chk = 0;
  int            n_fail = 0;
  int            cyc = 0;
  int            tot_pops = 0;
  logic [DW-1:0] src[$];
  item_t         mq[$];
  logic [DW-1:0] pend = '0;
  logic          pend_vld = 1'b0;
  logic          popped;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // One cycle against the model: a word fetched in cycle t is
  // deliverable from t+2; at most two words may be outstanding.
  task automatic step(input logic rdy);
    logic ev;
    logic ei;
    logic pp;
    item_t it;
    @(posedge r_clk);
    #1;
    r_ready    = rdy;
    r_empty    = (src.size() == 0);
    r_mem_data = pend_vld ? pend : DW'($urandom);
    @(negedge r_clk);
    cyc++;
    ev = (mq.size() > 0) && (mq[0].t <= cyc);
    chk("valid", r_valid, ev);
    if (ev) chk("data", r_data, mq[0].w);
    pp = ev & rdy;
    ei = !r_empty && ((mq.size() - int'(pp)) < 2);
    chk("inc", r_inc, ei);
`ifdef CDC_FIFO_RD_STREAM_CNT_EN
    chk("pop_cnt", r_pop_cnt, CW'(tot_pops));
`endif
    popped = pp;
    if (pp) begin
      void'(mq.pop_front());
      tot_pops++;
    end
    pend_vld = ei;
    if (ei) begin
      it.w = src.pop_front();
      it.t = cyc + 2;
      mq.push_back(it);
      pend = it.w;
    end
  endtask

  vec_t vt[12];

  initial begin
    int first_pop;
    int last_pop;
    int npop;

    vt[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00};
    vt[1]  = '{1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h00};
    vt[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[3]  = '{1'b1, 1'b1, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[4]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A};
    vt[5]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'h5A};
    vt[6]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[7]  = '{1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[8]  = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[9]  = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5};
    vt[10] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
    vt[11] = '{1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 12; i++) begin
      @(posedge r_clk);
      #1;
      r_rst_n    = vt[i].rst_n;
      r_empty    = vt[i].empty;
      r_ready    = vt[i].ready;
      r_mem_data = vt[i].mem;
      @(negedge r_clk);
      chk($sformatf("vec%0d_valid", i), r_valid, vt[i].exp_valid);
      chk($sformatf("vec%0d_inc", i), r_inc, vt[i].exp_inc);
      if (vt[i].chk_data)
        chk($sformatf("vec%0d_data", i), r_data, vt[i].exp_data);
    end
    tot_pops = 2;

    // streaming 0x01..0x10 with no gaps after the first word
    for (int i = 1; i <= 16; i++) src.push_back(DW'(i));
    first_pop = 0;
    last_pop = 0;
    npop = 0;
    for (int k = 0; k < 22; k++) begin
      step(1'b1);
      if (popped) begin
        if (npop == 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
    end
    chk("stream_count", npop, 16);
    chk("stream_gap", last_pop - first_pop, 15);

    // backpressure: r_ready low for cycles 3..10
    for (int i = 1; i <= 8; i++) src.push_back(DW'(i));
    npop = 0;
    for (int k = 0; k < 26; k++) begin
      step(!(k >= 3 && k <= 10));
      if (popped) npop++;
    end
    chk("bp_count", npop, 8);

    // mid-operation reset with a full buffer
    for (int i = 0; i < 5; i++) src.push_back(DW'(8'hC0 + i));
    for (int k = 0; k < 4; k++) step(1'b0);
    chk("pre_rst_valid", r_valid, 1'b1);
    #2;
    r_rst_n = 1'b0;
    r_empty = 1'b1;
    #1;
    chk("rst_async_valid", r_valid, 1'b0);
    chk("rst_async_data", r_data, 0);
    src.delete();
    mq.delete();
    pend_vld = 1'b0;
    tot_pops = 0;
    @(posedge r_clk);
    #1;
    r_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1);

    // 17 accepted words
    for (int i = 0; i < 17; i++) src.push_back(DW'($urandom));
    for (int k = 0; k < 24; k++) step(1'b1);
`ifdef CDC_FIFO_RD_STREAM_CNT_EN
    chk("cnt_wrap", r_pop_cnt, 1);
`endif

    // random traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 2) == 0)
        for (int j = 0; j < int'($urandom_range(1, 3)); j++)
          src.push_back(DW'($urandom));
      step($urandom_range(0, 3) != 0);
    end
    src.delete();
    for (int k = 0; k < 6; k++) step(1'b1);
    chk("final_drained", r_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
